// File: rtl/mcp_rf_mp_pkg.sv
// Shared register-index constants and FSM encoding for the multi-port MIPS register file.
package mcp_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_FP   = 30;
  localparam int REG_RA   = 31;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mcp_rf_mp_if.sv
// Register-file port bundle: decode/writeback side is master, the register file is slave.
interface mcp_rf_mp_if #(
    parameter int WL = 32,
    parameter int AL = 5,
    parameter int NR = 2,
    parameter int NW = 2
);
    import mcp_pkg::*;

    // No valid/ready handshake: write ports commit on every posedge where RFWE is set
    // and READY is high; reads are combinational. READY low means writes are dropped
    // and reads return zero.
    logic [NW-1:0]    RFWE;
    logic [NW*AL-1:0] RFWA;
    logic [NW*WL-1:0] RFWD;
    logic [NR*AL-1:0] RFRA;
    logic [NR*WL-1:0] RFRD;
    logic             READY;
    state_t           DBG_STATE;

    modport master (
        output RFWE, RFWA, RFWD, RFRA,
        input  RFRD, READY, DBG_STATE
    );

    modport slave (
        input  RFWE, RFWA, RFWD, RFRA,
        output RFRD, READY, DBG_STATE
    );

endinterface

// File: rtl/mcp_rf_mp_wr_arb.sv
// Folds NW write ports into one enable and data word per register; higher port index wins, reg 0 masked.
module mcp_rf_wr_arb #(
    parameter int WL = 32,
    parameter int AL = 5,
    parameter int NW = 2,
    localparam int DEPTH = 2**AL
) (
    input  logic [NW-1:0]       we_i,
    input  logic [NW*AL-1:0]    wa_i,
    input  logic [NW*WL-1:0]    wd_i,
    output logic [DEPTH-1:0]    we_o,
    output logic [DEPTH*WL-1:0] wd_o
);
    logic [AL-1:0] wa_d;

    // Ascending port scan: a later (higher) port overwrites a lower one on the same address.
    always_comb begin
        we_o = '0;
        wd_o = '0;
        wa_d = '0;
        for (int k = 0; k < NW; k++) begin
            wa_d = wa_i[k*AL +: AL];
            if (we_i[k] && (wa_d != '0)) begin
                we_o[wa_d]                = 1'b1;
                wd_o[int'(wa_d)*WL +: WL] = wd_i[k*WL +: WL];
            end
        end
    end

endmodule

// File: rtl/mcp_rf_mp.sv
// Multi-port register file with post-reset init sweep and hardwired $0.
// Optional write-first bypass enabled by defining MCP_RF_BYPASS_EN.
module mcp_rf_mp
    import mcp_pkg::*;
#(
    parameter int            WL      = 32,
    parameter int            AL      = 5,
    parameter int            NR      = 2,
    parameter int            NW      = 2,
    parameter logic [WL-1:0] GP_INIT = WL'(32'h10008000),
    parameter logic [WL-1:0] SP_INIT = WL'(32'h7FFFEFFC)
) (
    input  logic        CLK,
    input  logic        RST,
    mcp_rf_mp_if.slave  rf
);
    localparam int          DEPTH    = 2**AL;
    localparam logic [AL:0] LAST_IDX = (AL+1)'(DEPTH-1);

    state_t           state_q;
    logic [AL:0]      idx_q;
    logic             ready_q;
    logic [WL-1:0]    rf_q [DEPTH];
    logic [WL-1:0]    init_d;
    logic [DEPTH-1:0]    we_eff;
    logic [DEPTH*WL-1:0] wd_eff;
    logic [AL-1:0]    ra_d;
    logic [NR*WL-1:0] rd_d;

    mcp_rf_wr_arb #(.WL(WL), .AL(AL), .NW(NW)) u_arb (
        .we_i (rf.RFWE),
        .wa_i (rf.RFWA),
        .wd_i (rf.RFWD),
        .we_o (we_eff),
        .wd_o (wd_eff)
    );

    always_comb begin
        init_d = '0;
        if (int'(idx_q) == REG_GP)      init_d = GP_INIT;
        else if (int'(idx_q) == REG_SP) init_d = SP_INIT;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rf_q[idx_q[AL-1:0]] <= init_d;
                    idx_q               <= idx_q + (AL+1)'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    for (int a = 1; a < DEPTH; a++) begin
                        if (we_eff[a]) rf_q[a] <= wd_eff[a*WL +: WL];
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Reads are forced to zero until the sweep completes, and always for reg 0.
    always_comb begin
        rd_d = '0;
        ra_d = '0;
        for (int j = 0; j < NR; j++) begin
            ra_d = rf.RFRA[j*AL +: AL];
            if (ready_q && (int'(ra_d) != REG_ZERO)) begin
                rd_d[j*WL +: WL] = rf_q[ra_d];
`ifdef MCP_RF_BYPASS_EN
                if (we_eff[ra_d]) rd_d[j*WL +: WL] = wd_eff[int'(ra_d)*WL +: WL];
`endif
            end
        end
    end

    assign rf.RFRD      = rd_d;
    assign rf.READY     = ready_q;
    assign rf.DBG_STATE = state_q;

endmodule
